// File: rtl/ntt_stream_fifo.sv
// FWFT stream FIFO for NTT inter-stage channels with a registered head word.
// Define STREAM_FIFO_ERR_EN to add sticky overflow/underflow flags.
module ntt_stream_fifo #(
  parameter int DATA_WIDTH = 65,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_write,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_peek_dout,
  output logic                  if_peek_empty_n,
  output logic [ADDR_WIDTH:0]   if_count
`ifdef STREAM_FIFO_ERR_EN
  ,
  output logic                  err_overflow,
  output logic                  err_underflow
`endif
);

  localparam logic [ADDR_WIDTH:0] FULL =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE =
    (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_nxt;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   cnt_nxt;
  logic                  push;
  logic                  pop;
  logic                  bypass;

  assign push   = if_write & if_full_n;
  assign pop    = if_read & if_empty_n;
  assign rd_nxt = rd_ptr + ADDR_WIDTH'(1);

  // Storage may not hold the word yet when it becomes head.
  assign bypass = push &
    ((count == '0) | (pop & (count == ONE)));

  always_comb begin
    cnt_nxt = count;
    unique case (1'b1)
      push & ~pop: cnt_nxt = count + ONE;
      pop & ~push: cnt_nxt = count - ONE;
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr] <= if_din;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      if_full_n  <= 1'b1;
      if_empty_n <= 1'b0;
      if_dout    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_nxt;
      count      <= cnt_nxt;
      if_full_n  <= (cnt_nxt != FULL);
      if_empty_n <= (cnt_nxt != '0);
      if (bypass)   if_dout <= if_din;
      else if (pop) if_dout <= mem[rd_nxt];
    end
  end

  assign if_peek_dout    = if_dout;
  assign if_peek_empty_n = if_empty_n;
  assign if_count        = count;

`ifdef STREAM_FIFO_ERR_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (if_write & ~if_full_n)
        err_overflow <= 1'b1;
      if (if_read & ~if_empty_n)
        err_underflow <= 1'b1;
    end
  end
`endif

endmodule
